// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx -- oversampling UART receiver with a one-word output buffer.
//
// The asynchronous serial line is synchronized, a falling edge starts a frame,
// and every bit is sampled once at its middle using an oversample tick. A
// completed word is presented on a valid/ready handshake; if the consumer still
// holds the previous word when a new one completes, the new word is dropped and
// the sticky overrun flag is raised.
//
// Optional feature macro: UART_RX_PARITY_EN
//   defined   : one parity bit follows the data bits; parity_odd selects odd (1)
//               or even (0) parity and parity_err reports a mismatch.
//   undefined : frames are start + data + stop; parity_err is tied to 0.
//
// Parameters
//   DATA_WIDTH    data bits per frame (5..8)
//   BAUD_DIVISOR  pclk cycles per oversample tick (>= 2)
//   OVERSAMPLE    oversample ticks per bit period (even, >= 8)
//
// Ports
//   pclk         in   clock, all state updates on the rising edge
//   areset       in   asynchronous active-low reset
//   rx           in   serial line, idle high, asynchronous to pclk
//   rx_ready     in   consumer accepts rx_data when rx_valid && rx_ready
//   overrun_clr  in   clears overrun on the next edge (a new overrun wins)
//   parity_odd   in   parity sense, present only with UART_RX_PARITY_EN
//   rx_data      out  received word, first bit on the line is the LSB
//   rx_valid     out  rx_data holds an unconsumed word
//   frame_err    out  stop bit of the buffered word was low
//   parity_err   out  parity mismatch on the buffered word
//   overrun      out  sticky, a completed word was dropped
// -----------------------------------------------------------------------------
module uart_rx #(
    parameter int DATA_WIDTH   = 8,
    parameter int BAUD_DIVISOR = 27,
    parameter int OVERSAMPLE   = 16
) (
    input  logic                  pclk,
    input  logic                  areset,
    input  logic                  rx,
    input  logic                  rx_ready,
    input  logic                  overrun_clr,
`ifdef UART_RX_PARITY_EN
    input  logic                  parity_odd,
`endif
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam int BW = $clog2(BAUD_DIVISOR);
    localparam int OW = $clog2(OVERSAMPLE);
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [BW-1:0] BAUD_LAST    = BW'(BAUD_DIVISOR - 1);
    localparam logic [OW-1:0] OS_LAST      = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_HALF_LAST = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] DATA_LAST    = CW'(DATA_WIDTH - 1);

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_START     = 3'd1;
    localparam logic [2:0] ST_DATA      = 3'd2;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] ST_PARITY    = 3'd3;
`endif
    localparam logic [2:0] ST_STOP      = 3'd4;
    localparam logic [2:0] ST_WAIT_HIGH = 3'd5;

    // -------------------------------------------------------------------------
    // Line synchronizer and falling-edge detector
    // -------------------------------------------------------------------------
    logic rx_meta_q;
    logic rx_sync_q;
    logic rx_prev_q;
    logic start_edge;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, whatever the block order.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            // Reset to the idle level so release never fakes a start edge.
            rx_meta_q <= 1'b1;
            rx_sync_q <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= rx;
            rx_sync_q <= rx_meta_q;
            rx_prev_q <= rx_sync_q;
        end
    end

    assign start_edge = rx_prev_q & ~rx_sync_q;

    // -------------------------------------------------------------------------
    // Receiver state
    // -------------------------------------------------------------------------
    logic [2:0]            state_q,    state_d;
    logic [BW-1:0]         baud_cnt_q, baud_cnt_d;
    logic [OW-1:0]         os_cnt_q,   os_cnt_d;
    logic [CW-1:0]         bit_cnt_q,  bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q,    shift_d;
`ifdef UART_RX_PARITY_EN
    logic                  par_err_q,  par_err_d;
`endif
    logic                  baud_tick;
    logic                  frame_done;
    logic                  frame_err_new;

    // The baud divider is parked at 0 in IDLE, so it always starts a fresh
    // count on the cycle the FSM enters START.
    assign baud_tick  = (state_q != ST_IDLE) && (baud_cnt_q == BAUD_LAST);
    assign baud_cnt_d = ((state_q == ST_IDLE) || baud_tick) ? '0 : baud_cnt_q + 1'b1;

    // NOTE: every signal written in this always_comb gets a default first, so
    // no path through the case statement can infer a latch.
    always_comb begin
        state_d       = state_q;
        os_cnt_d      = os_cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
`ifdef UART_RX_PARITY_EN
        par_err_d     = par_err_q;
`endif
        frame_done    = 1'b0;
        frame_err_new = 1'b0;

        case (state_q)
            ST_IDLE: begin
                os_cnt_d  = '0;
                bit_cnt_d = '0;
                if (start_edge) begin
                    state_d = ST_START;
                end
            end

            // Confirm the start bit at its middle; a short low pulse has
            // already gone high again and is rejected silently.
            ST_START: begin
                if (baud_tick) begin
                    if (os_cnt_q == OS_HALF_LAST) begin
                        os_cnt_d = '0;
                        state_d  = rx_sync_q ? ST_IDLE : ST_DATA;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end

            // From the middle of the start bit, a full bit period later is the
            // middle of the next bit. Bits enter at the MSB and shift down, so
            // the first bit on the line ends up in bit 0.
            ST_DATA: begin
                if (baud_tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d = '0;
                        shift_d  = {rx_sync_q, shift_q[DATA_WIDTH-1:1]};
                        if (bit_cnt_q == DATA_LAST) begin
                            bit_cnt_d = '0;
`ifdef UART_RX_PARITY_EN
                            state_d   = ST_PARITY;
`else
                            state_d   = ST_STOP;
`endif
                        end else begin
                            bit_cnt_d = bit_cnt_q + 1'b1;
                        end
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end

`ifdef UART_RX_PARITY_EN
            // Even parity: data bits plus parity bit must XOR to 0; odd
            // parity flips the expectation.
            ST_PARITY: begin
                if (baud_tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d  = '0;
                        par_err_d = (^shift_q) ^ rx_sync_q ^ parity_odd;
                        state_d   = ST_STOP;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end
`endif

            // The frame completes at the stop-bit sample either way; a low
            // stop bit means a break or a framing fault, so the line must go
            // high before another start edge is trusted.
            ST_STOP: begin
                if (baud_tick) begin
                    if (os_cnt_q == OS_LAST) begin
                        os_cnt_d      = '0;
                        frame_done    = 1'b1;
                        frame_err_new = ~rx_sync_q;
                        state_d       = rx_sync_q ? ST_IDLE : ST_WAIT_HIGH;
                    end else begin
                        os_cnt_d = os_cnt_q + 1'b1;
                    end
                end
            end

            ST_WAIT_HIGH: begin
                os_cnt_d = '0;
                if (rx_sync_q) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                os_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            os_cnt_q   <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            os_cnt_q   <= os_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
`ifdef UART_RX_PARITY_EN
            par_err_q  <= par_err_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Output buffer and handshake
    // -------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q;
    logic                  frame_err_q;
    logic                  overrun_q;
    logic                  accept;
    logic                  load;
    logic                  drop;

    // A word being accepted on the same edge frees the buffer for the new one.
    assign accept = rx_valid_q & rx_ready;
    assign load   = frame_done & (~rx_valid_q | rx_ready);
    assign drop   = frame_done & rx_valid_q & ~rx_ready;

    // NOTE: the data buffer is reset like any control flop, so rx_data reads 0
    // after reset rather than whatever the flops powered up with.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (load) begin
            rx_data_q   <= shift_q;
            rx_valid_q  <= 1'b1;
            frame_err_q <= frame_err_new;
        end else if (accept) begin
            rx_valid_q  <= 1'b0;
        end
    end

    // A drop in the same cycle as a clear request leaves the flag set.
    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            overrun_q <= 1'b0;
        end else if (drop) begin
            overrun_q <= 1'b1;
        end else if (overrun_clr) begin
            overrun_q <= 1'b0;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic parity_err_q;

    always_ff @(posedge pclk or negedge areset) begin
        if (!areset) begin
            parity_err_q <= 1'b0;
        end else if (load) begin
            parity_err_q <= par_err_q;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx (BAUD_DIVISOR=4, OVERSAMPLE=16,
// so one bit lasts 64 pclk). Frames are driven bit by bit on rx; the model
// predicts each word (data, frame error, parity error) or its loss to overrun
// from the frame contents and whether the consumer is stalled with a word
// already pending. A compare process checks every accepted word against the
// model; directed scenarios pin the model with literal values.
// Build with +define+UART_RX_PARITY_EN to include the parity frames.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int DW  = 8;
    localparam int BD  = 4;
    localparam int OS  = 16;
    localparam int BIT = BD * OS;

    logic          pclk        = 1'b0;
    logic          areset      = 1'b1;
    logic          rx          = 1'b1;
    logic          rx_ready    = 1'b0;
    logic          overrun_clr = 1'b0;
`ifdef UART_RX_PARITY_EN
    logic          parity_odd  = 1'b0;
`endif
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          frame_err;
    logic          parity_err;
    logic          overrun;

    uart_rx #(
        .DATA_WIDTH   (DW),
        .BAUD_DIVISOR (BD),
        .OVERSAMPLE   (OS)
    ) dut (
        .pclk        (pclk),
        .areset      (areset),
        .rx          (rx),
        .rx_ready    (rx_ready),
        .overrun_clr (overrun_clr),
`ifdef UART_RX_PARITY_EN
        .parity_odd  (parity_odd),
`endif
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun)
    );

    always #5 pclk = ~pclk;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          fe;
        logic          pe;
    } word_t;

    word_t         exp_q[$];
    logic          exp_overrun  = 1'b0;
    int            ready_mode   = 0;    // 0: stalled, 1: always ready, 2: random
    int            n_checks     = 0;
    int            n_pass       = 0;
    int            valid_hi_cnt = 0;
    int            acc_cnt      = 0;
    logic [DW-1:0] last_data    = '0;
    logic          last_fe      = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Consumer: rx_ready changes just after each rising edge.
    initial begin
        forever begin
            @(posedge pclk);
            #1;
            case (ready_mode)
                0:       rx_ready = 1'b0;
                1:       rx_ready = 1'b1;
                default: rx_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard: every word the consumer takes must be the oldest expected one.
    always @(negedge pclk) begin
        if (areset) begin
            if (rx_valid) valid_hi_cnt++;
            if (rx_valid && rx_ready) begin
                word_t e;
                acc_cnt++;
                last_data = rx_data;
                last_fe   = frame_err;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    $display("FAIL unexpected_word: got 0x%0h, expected no word (t=%0t)", rx_data, $time);
                end else begin
                    e = exp_q.pop_front();
                    check("word_data", 32'(rx_data), 32'(e.data));
                    check("word_frame_err", 32'(frame_err), 32'(e.fe));
                    check("word_parity_err", 32'(parity_err), 32'(e.pe));
                end
            end
        end
    end

    // All stimulus tasks start and end 1 time unit after a rising edge.
    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT) @(posedge pclk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge pclk);
        #1;
    endtask

    function automatic logic even_par(input logic [DW-1:0] d);
        return ^d;
    endfunction

    // Sends start, data (LSB first), optional parity, stop. Leaves rx at the
    // stop-bit level. The model decides the fate of the word at the start of
    // the stop bit: a stalled consumer with a word still pending loses it.
    task automatic send_frame(input logic [DW-1:0] d, input logic pbit, input logic stop_bit);
        word_t w;
        logic  pe;
        drive_bit(1'b0);
        for (int i = 0; i < DW; i++) drive_bit(d[i]);
        pe = 1'b0;
`ifdef UART_RX_PARITY_EN
        drive_bit(pbit);
        pe = (^d) ^ pbit ^ parity_odd;
`else
        if (pbit) pe = 1'b0;
`endif
        if (ready_mode == 0 && exp_q.size() > 0) begin
            exp_overrun = 1'b1;
        end else begin
            w.data = d;
            w.fe   = ~stop_bit;
            w.pe   = pe;
            exp_q.push_back(w);
        end
        drive_bit(stop_bit);
        check("overrun_after_frame", 32'(overrun), 32'(exp_overrun));
    endtask

    initial begin
        logic [DW-1:0] d;
        logic          stop_bit;
        logic          pbit;

        // ---------------- reset state ----------------
        #1 areset = 1'b0;
        #2;
        check("reset_rx_valid", 32'(rx_valid), 32'd0);
        check("reset_rx_data", 32'(rx_data), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        repeat (3) @(negedge pclk);
        #2 areset = 1'b1;
        @(posedge pclk);
        #1;
        idle(20);

        // ---------------- 0xA5 8N1, consumer always ready ----------------
        ready_mode   = 1;
        idle(2);
        valid_hi_cnt = 0;
        send_frame(8'hA5, even_par(8'hA5), 1'b1);
        idle(20);
        check("a5_data", 32'(last_data), 32'hA5);
        check("a5_valid_cycles", 32'(valid_hi_cnt), 32'd1);
        check("a5_frame_err", 32'(last_fe), 32'd0);

        // ---------------- 20-cycle glitch on idle line ----------------
        valid_hi_cnt = 0;
        rx = 1'b0;
        repeat (20) @(posedge pclk);
        #1;
        idle(200);
        check("glitch_no_valid", 32'(valid_hi_cnt), 32'd0);
        send_frame(8'h5A, even_par(8'h5A), 1'b1);
        idle(20);
        check("post_glitch_data", 32'(last_data), 32'h5A);

        // ---------------- overrun with stalled consumer ----------------
        ready_mode = 0;
        idle(5);
        send_frame(8'h3C, even_par(8'h3C), 1'b1);
        idle(10);
        send_frame(8'h81, even_par(8'h81), 1'b1);
        idle(10);
        check("ovr_valid", 32'(rx_valid), 32'd1);
        check("ovr_data_kept", 32'(rx_data), 32'h3C);
        check("ovr_flag", 32'(overrun), 32'd1);
        overrun_clr = 1'b1;
        @(posedge pclk);
        #1 overrun_clr = 1'b0;
        exp_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);
        ready_mode = 1;
        idle(5);
        ready_mode = 0;
        idle(2);
        check("ovr_valid_released", 32'(rx_valid), 32'd0);

        // ---------------- low stop bit followed by a long break ----------------
        send_frame(8'h55, even_par(8'h55), 1'b0);
        rx = 1'b0;
        repeat (3 * BIT) @(posedge pclk);
        #1;
        check("brk_valid", 32'(rx_valid), 32'd1);
        check("brk_data", 32'(rx_data), 32'h55);
        check("brk_frame_err", 32'(frame_err), 32'd1);
        check("brk_no_second_word", 32'(overrun), 32'd0);
        ready_mode = 1;
        idle(30);
        send_frame(8'h12, even_par(8'h12), 1'b1);
        idle(20);
        check("brk_recover_data", 32'(last_data), 32'h12);

`ifdef UART_RX_PARITY_EN
        // ---------------- parity, even sense ----------------
        parity_odd = 1'b0;
        ready_mode = 0;
        idle(5);
        send_frame(8'h07, 1'b0, 1'b1);
        idle(5);
        check("par0_data", 32'(rx_data), 32'h07);
        check("par0_err", 32'(parity_err), 32'd1);
        ready_mode = 1;
        idle(10);
        ready_mode = 0;
        send_frame(8'h07, 1'b1, 1'b1);
        idle(5);
        check("par1_err", 32'(parity_err), 32'd0);
        ready_mode = 1;
        idle(10);
`endif

        // ---------------- reset in the middle of a frame ----------------
        ready_mode = 0;
        idle(5);
        send_frame(8'h3C, even_par(8'h3C), 1'b1);
        idle(5);
        drive_bit(1'b0);
        for (int i = 0; i < 3; i++) drive_bit(1'b0);  // low bits of 0xF0
        #3 areset = 1'b0;
        rx = 1'b1;
        #1;
        check("async_rst_valid", 32'(rx_valid), 32'd0);
        check("async_rst_data", 32'(rx_data), 32'd0);
        exp_q.delete();
        exp_overrun = 1'b0;
        repeat (5) @(posedge pclk);
        #3 areset = 1'b1;
        ready_mode = 1;
        acc_cnt    = 0;
        @(posedge pclk);
        #1;
        idle(20);
        check("post_rst_valid", 32'(rx_valid), 32'd0);
        send_frame(8'h12, even_par(8'h12), 1'b1);
        idle(20);
        check("post_rst_data", 32'(last_data), 32'h12);
        check("post_rst_words", 32'(acc_cnt), 32'd1);

        // ---------------- randomized frames, random consumer ----------------
        ready_mode = 2;
        for (int n = 0; n < 30; n++) begin
            d        = DW'($urandom);
            stop_bit = ($urandom_range(0, 7) != 0);
            pbit     = 1'($urandom_range(0, 1));
`ifdef UART_RX_PARITY_EN
            parity_odd = 1'($urandom_range(0, 1));
`endif
            send_frame(d, pbit, stop_bit);
            if (!stop_bit) idle(10 + $urandom_range(0, 50));
            else           idle($urandom_range(0, 40));
        end

        // ---------------- drain ----------------
        ready_mode = 1;
        idle(100);
        check("all_words_delivered", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
